// File: rtl/mcpu_main_ctrl_pkg.sv
// rtl/mcpu_main_ctrl_pkg.sv - shared constants, state encoding and helpers for the multi-cycle MIPS control FSM
//
// Purpose: one place for the ALUOp codes consumed by alu_ctrl, the supported
// opcodes and the 4-bit state encoding (FETCH=0 .. JUMP=9).
package mcpu_main_ctrl_pkg;

    // ALUOp codes driven to alu_ctrl
    localparam logic [1:0] ALUOP_LW    = 2'b00;
    localparam logic [1:0] ALUOP_SW    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_BEQ   = 2'b11;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    // States that wait on mem_ready and are covered by the timeout
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mcpu_main_ctrl_wait_timer.sv
// rtl/mcpu_main_ctrl_wait_timer.sv - memory wait-state counter with bounded timeout (module mcpu_wait_timer)
//
// Ports:
//  clk, rst  clock / async active-high reset
//  active    FSM is in a memory state (FETCH/MEMRD/MEMWR)
//  ready     mem_ready from memory
//  timeout   active, not ready, and WAIT_MAX cycles already spent waiting
module mcpu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    logic [7:0] wait_cnt;
    logic       hold;

    assign timeout = active && !ready && (wait_cnt == 8'(WAIT_MAX));

    // The counter keeps counting only while the FSM stays in the same memory
    // state; any exit (completion, abort, or not being in a memory state)
    // returns it to zero, so every entry into a memory state starts from 0,
    // including FETCH re-entered from an aborted FETCH.
    assign hold = active && !ready && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (hold) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/mcpu_main_ctrl.sv
// rtl/mcpu_main_ctrl.sv - main control FSM of the multi-cycle MIPS CPU
//
// Ports:
//  clk, rst        clock / async active-high reset
//  Op              IR[31:26], used in DECODE and MEMADR only
//  mem_ready       memory completes the current access this cycle
//  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp
//                  datapath controls (Moore decode of state, some gated by mem_ready)
//  instr_done      pulse on the last cycle of each instruction
//  illegal_op      pulse in DECODE for an unsupported opcode
//  mem_err         pulse when a memory state times out
module mcpu_main_ctrl
    import mcpu_main_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err
);

    state_t state, state_next;
    logic   timeout;

    mcpu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (is_mem_state(state)),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        PCSource    = 2'd0;
        ALUOp       = ALUOP_LW;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;

        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                // IR and PC commit only with the data; on timeout nothing commits
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    instr_done = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ALUSrcB = 2'd3;
                case (Op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE:     state_next = ST_EXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                if (Op == OP_SW) begin
                    ALUOp      = ALUOP_SW;
                    state_next = ST_MEMWR;
                end else begin
                    state_next = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_next = ST_MEMWB;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    instr_done = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = ST_FETCH;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    instr_done = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_RTYPE;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_BEQ;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                instr_done  = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'd2;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mcpu_main_ctrl.sv
// tb/tb_mcpu_main_ctrl.sv - table-driven scoreboard bench for mcpu_main_ctrl
module tb_mcpu_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic       instr_done, illegal_op, mem_err;

    always #5 clk = ~clk;

    mcpu_main_ctrl #(.WAIT_MAX(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_err     (mem_err)
    );

    // Packed view: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    //               RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,done,illegal,err}
    logic [18:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                  instr_done, illegal_op, mem_err};

    localparam logic [18:0] B_PCW   = 19'd1 << 18;
    localparam logic [18:0] B_PCWC  = 19'd1 << 17;
    localparam logic [18:0] B_IORD  = 19'd1 << 16;
    localparam logic [18:0] B_MRD   = 19'd1 << 15;
    localparam logic [18:0] B_MWR   = 19'd1 << 14;
    localparam logic [18:0] B_IRW   = 19'd1 << 13;
    localparam logic [18:0] B_M2R   = 19'd1 << 12;
    localparam logic [18:0] B_RDST  = 19'd1 << 11;
    localparam logic [18:0] B_RW    = 19'd1 << 10;
    localparam logic [18:0] B_SRCA  = 19'd1 << 9;
    localparam logic [18:0] B_SRCB1 = 19'd1 << 7;
    localparam logic [18:0] B_SRCB2 = 19'd2 << 7;
    localparam logic [18:0] B_SRCB3 = 19'd3 << 7;
    localparam logic [18:0] B_PCS1  = 19'd1 << 5;
    localparam logic [18:0] B_PCS2  = 19'd2 << 5;
    localparam logic [18:0] B_AOPSW = 19'd1 << 3;
    localparam logic [18:0] B_AOPR  = 19'd2 << 3;
    localparam logic [18:0] B_AOPBQ = 19'd3 << 3;
    localparam logic [18:0] B_DONE  = 19'd1 << 2;
    localparam logic [18:0] B_ILL   = 19'd1 << 1;
    localparam logic [18:0] B_ERR   = 19'd1;

    localparam logic [18:0] E_FW    = B_MRD | B_SRCB1;
    localparam logic [18:0] E_FR    = B_MRD | B_SRCB1 | B_IRW | B_PCW;
    localparam logic [18:0] E_FTO   = B_MRD | B_SRCB1 | B_DONE | B_ERR;
    localparam logic [18:0] E_DEC   = B_SRCB3;
    localparam logic [18:0] E_DILL  = B_SRCB3 | B_ILL | B_DONE;
    localparam logic [18:0] E_MALW  = B_SRCA | B_SRCB2;
    localparam logic [18:0] E_MASW  = B_SRCA | B_SRCB2 | B_AOPSW;
    localparam logic [18:0] E_MRD   = B_MRD | B_IORD;
    localparam logic [18:0] E_MRDTO = B_MRD | B_IORD | B_DONE | B_ERR;
    localparam logic [18:0] E_MWB   = B_RW | B_M2R | B_DONE;
    localparam logic [18:0] E_MWRW  = B_MWR | B_IORD;
    localparam logic [18:0] E_MWRR  = B_MWR | B_IORD | B_DONE;
    localparam logic [18:0] E_EX    = B_SRCA | B_AOPR;
    localparam logic [18:0] E_AWB   = B_RW | B_RDST | B_DONE;
    localparam logic [18:0] E_BR    = B_SRCA | B_AOPBQ | B_PCWC | B_PCS1 | B_DONE;
    localparam logic [18:0] E_J     = B_PCW | B_PCS2 | B_DONE;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t        vt[$];
    string       sb_name[$];
    logic [18:0] sb_exp[$];
    int          vec_cnt  = 0;
    int          miss_cnt = 0;

    task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
        vec_cnt++;
        if (a !== e) begin
            miss_cnt++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic add(input string name, input logic [5:0] o, input logic r, input logic [18:0] e);
        vec_t v;
        v.name = name;
        v.op   = o;
        v.rdy  = r;
        v.exp  = e;
        vt.push_back(v);
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show in it
    task automatic apply(input string name, input logic [5:0] o, input logic r, input logic [18:0] e);
        Op        = o;
        mem_ready = r;
        sb_name.push_back(name);
        sb_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_exp.size() > 0) begin
            check(sb_name.pop_front(), act, sb_exp.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        Op        = 6'h00;
        mem_ready = 1'b0;

        // R-type, with Op/mem_ready noise in EXEC that must be ignored
        add("r_fetch",   6'h00, 1'b1, E_FR);
        add("r_decode",  6'h00, 1'b0, E_DEC);
        add("r_exec",    6'h3f, 1'b1, E_EX);
        add("r_aluwb",   6'h23, 1'b0, E_AWB);
        // lw with three wait states in MEMRD (8 cycles)
        add("lw_fetch",  6'h23, 1'b1, E_FR);
        add("lw_decode", 6'h23, 1'b0, E_DEC);
        add("lw_memadr", 6'h23, 1'b0, E_MALW);
        add("lw_memrd0", 6'h00, 1'b0, E_MRD);
        add("lw_memrd1", 6'h00, 1'b0, E_MRD);
        add("lw_memrd2", 6'h00, 1'b0, E_MRD);
        add("lw_memrd3", 6'h00, 1'b1, E_MRD);
        add("lw_memwb",  6'h00, 1'b0, E_MWB);
        // sw with one wait state
        add("sw_fetch",  6'h2b, 1'b1, E_FR);
        add("sw_decode", 6'h2b, 1'b0, E_DEC);
        add("sw_memadr", 6'h2b, 1'b0, E_MASW);
        add("sw_memwr0", 6'h2b, 1'b0, E_MWRW);
        add("sw_memwr1", 6'h2b, 1'b1, E_MWRR);
        // beq and j
        add("beq_fetch", 6'h04, 1'b1, E_FR);
        add("beq_decode",6'h04, 1'b0, E_DEC);
        add("beq_branch",6'h04, 1'b1, E_BR);
        add("j_fetch",   6'h02, 1'b1, E_FR);
        add("j_decode",  6'h02, 1'b0, E_DEC);
        add("j_jump",    6'h02, 1'b0, E_J);
        // FETCH timeout twice in a row: counter must restart on re-entry
        add("to_f0",     6'h00, 1'b0, E_FW);
        add("to_f1",     6'h00, 1'b0, E_FW);
        add("to_f2",     6'h00, 1'b0, E_FW);
        add("to_f3",     6'h00, 1'b0, E_FTO);
        add("to_g0",     6'h00, 1'b0, E_FW);
        add("to_g1",     6'h00, 1'b0, E_FW);
        add("to_g2",     6'h00, 1'b0, E_FW);
        add("to_g3",     6'h00, 1'b0, E_FTO);
        // mem_ready at the timeout boundary wins, then an illegal opcode
        add("win_f0",    6'h3f, 1'b0, E_FW);
        add("win_f1",    6'h3f, 1'b0, E_FW);
        add("win_f2",    6'h3f, 1'b0, E_FW);
        add("win_f3",    6'h3f, 1'b1, E_FR);
        add("ill_decode",6'h3f, 1'b0, E_DILL);
        // MEMRD timeout aborts back to FETCH
        add("rto_fetch", 6'h23, 1'b0, E_FW);
        add("rto_fetch1",6'h23, 1'b1, E_FR);
        add("rto_decode",6'h23, 1'b0, E_DEC);
        add("rto_memadr",6'h23, 1'b0, E_MALW);
        add("rto_rd0",   6'h00, 1'b0, E_MRD);
        add("rto_rd1",   6'h00, 1'b0, E_MRD);
        add("rto_rd2",   6'h00, 1'b0, E_MRD);
        add("rto_rd3",   6'h00, 1'b0, E_MRDTO);
        add("rto_after", 6'h00, 1'b0, E_FW);

        @(posedge clk);
        #1;
        apply("reset_hold", 6'h00, 1'b0, E_FW);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].name, vt[i].op, vt[i].rdy, vt[i].exp);
        end

        // Async reset in the middle of a store
        apply("rs_fetch",  6'h2b, 1'b1, E_FR);
        apply("rs_decode", 6'h2b, 1'b0, E_DEC);
        apply("rs_memadr", 6'h2b, 1'b0, E_MASW);
        apply("rs_memwr",  6'h2b, 1'b0, E_MWRW);
        rst = 1'b1;
        #1;
        check("rs_async_outputs", act, E_FW);
        check("rs_async_memwrite", {18'd0, MemWrite}, 19'd0);
        apply("rs_held",   6'h2b, 1'b0, E_FW);
        rst = 1'b0;
        apply("rs2_fetch", 6'h00, 1'b1, E_FR);
        apply("rs2_decode",6'h00, 1'b0, E_DEC);
        apply("rs2_exec",  6'h00, 1'b0, E_EX);
        apply("rs2_aluwb", 6'h00, 1'b0, E_AWB);
        apply("rs2_next",  6'h00, 1'b0, E_FW);

        check("scoreboard_drained", 19'(sb_exp.size()), 19'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
